// File: rtl/traffic_pkg.sv
// Shared light codes, guard states and fault codes for the traffic lamp guard slice.
package traffic_pkg;

    localparam logic [2:0] RED      = 3'b100;
    localparam logic [2:0] GREEN    = 3'b010;
    localparam logic [2:0] YELLOW   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLASH = 2'd2
    } guard_state_t;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ENC   = 2'b01;
    localparam logic [1:0] FC_ORDER = 2'b10;
    localparam logic [1:0] FC_DWELL = 2'b11;

    function automatic logic legal_code(input logic [2:0] code);
        return (code == RED) || (code == GREEN) || (code == YELLOW);
    endfunction

    // Only successor allowed after a legal code: GREEN->YELLOW->RED->GREEN.
    function automatic logic [2:0] next_code(input logic [2:0] code);
        logic [2:0] nxt;
        case (code)
            GREEN:   nxt = YELLOW;
            YELLOW:  nxt = RED;
            RED:     nxt = GREEN;
            default: nxt = LAMP_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// Flash-mode blink phase: on for BLINK_HALF cycles, off for BLINK_HALF cycles; en low holds phase on, count 0.
module traffic_blink_gen #(
    parameter int BLINK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blink_on
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt      <= '0;
            blink_on <= 1'b1;
        end else if (cnt == LAST) begin
            cnt      <= '0;
            blink_on <= ~blink_on;
        end else begin
            cnt <= cnt + BW'(1);
        end
    end

endmodule

// File: rtl/traffic_lamp_guard.sv
// Safety guard between the signal FSM and the lamp drivers; latches the first fault and flashes yellow.
// Optional minimum-dwell check compiled in with `define TRAFFIC_GUARD_DWELL_EN.
module traffic_lamp_guard
    import traffic_pkg::*;
#(
    parameter int BLINK_HALF = 4,
    parameter int MIN_DWELL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_in,
    output logic [2:0] lamp,
    output logic       fault,
    output logic [1:0] fault_code
);

    if (BLINK_HALF < 1) begin : g_bad_blink_half
        $error("BLINK_HALF must be at least 1");
    end
    if (MIN_DWELL < 1) begin : g_bad_min_dwell
        $error("MIN_DWELL must be at least 1");
    end

    guard_state_t state;
    logic [2:0]   lamp_q;
    logic [2:0]   prev;
    logic         blink_on;
    logic         hold;
    logic [1:0]   next_fc;

`ifdef TRAFFIC_GUARD_DWELL_EN
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
    logic [DW-1:0] dwell_cnt;
`endif

    traffic_blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk      (clk),
        .rst      (rst),
        .en       (state == FLASH),
        .blink_on (blink_on)
    );

    // prev is always legal in RUN, so a hold can never be an encoding fault.
    always_comb begin
        hold    = (light_in == prev);
        next_fc = FC_NONE;
        if (!hold) begin
            if (!legal_code(light_in)) begin
                next_fc = FC_ENC;
            end else if (light_in != next_code(prev)) begin
                next_fc = FC_ORDER;
            end
`ifdef TRAFFIC_GUARD_DWELL_EN
            else if (dwell_cnt < DWELL_MAX) begin
                next_fc = FC_DWELL;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            lamp_q     <= RED;
            prev       <= RED;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
`ifdef TRAFFIC_GUARD_DWELL_EN
            dwell_cnt  <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
                    if (legal_code(light_in)) begin
                        state  <= RUN;
                        lamp_q <= light_in;
                        prev   <= light_in;
`ifdef TRAFFIC_GUARD_DWELL_EN
                        dwell_cnt <= DW'(1);
`endif
                    end
                end
                RUN: begin
                    if (hold) begin
`ifdef TRAFFIC_GUARD_DWELL_EN
                        if (dwell_cnt < DWELL_MAX) begin
                            dwell_cnt <= dwell_cnt + DW'(1);
                        end
`endif
                    end else if (next_fc != FC_NONE) begin
                        state      <= FLASH;
                        lamp_q     <= YELLOW;
                        fault      <= 1'b1;
                        fault_code <= next_fc;
                    end else begin
                        lamp_q <= light_in;
                        prev   <= light_in;
`ifdef TRAFFIC_GUARD_DWELL_EN
                        dwell_cnt <= DW'(1);
`endif
                    end
                end
                FLASH: begin
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Flash output is a mux of flops: entering FLASH sets lamp_q to YELLOW and blink_on is already on.
    assign lamp = (state == FLASH) ? (blink_on ? YELLOW : LAMP_OFF) : lamp_q;

endmodule

// File: tb/tb_traffic_lamp_guard.sv
// Randomized + directed bench for traffic_lamp_guard, two parameterisations against a behavioural model.
module tb_traffic_lamp_guard;

    logic       clk;
    logic       rst;
    logic [2:0] light_in;
    logic [2:0] lamp_a, lamp_b;
    logic       fault_a, fault_b;
    logic [1:0] fc_a, fc_b;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

`ifdef TRAFFIC_GUARD_DWELL_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLASH = 2;

    int         bh[2] = '{4, 1};
    int         md[2] = '{1, 3};
    int         m_mode[2];
    logic [2:0] m_prev[2];
    int         m_held[2];
    int         m_age[2];
    logic       m_fault[2];
    logic [1:0] m_fc[2];

    traffic_lamp_guard #(.BLINK_HALF(4), .MIN_DWELL(1)) dut_a (
        .clk(clk), .rst(rst), .light_in(light_in),
        .lamp(lamp_a), .fault(fault_a), .fault_code(fc_a)
    );

    traffic_lamp_guard #(.BLINK_HALF(1), .MIN_DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .light_in(light_in),
        .lamp(lamp_b), .fault(fault_b), .fault_code(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    // Legal cycle is a right-rotate of the one-hot code: 010 -> 001 -> 100 -> 010.
    function automatic logic [2:0] succ(input logic [2:0] v);
        return {v[0], v[2:1]};
    endfunction

    task automatic model_edge(input int i, input logic r, input logic [2:0] v);
        logic [1:0] c;
        if (r) begin
            m_mode[i]  = M_INIT;
            m_fault[i] = 1'b0;
            m_fc[i]    = 2'b00;
            m_held[i]  = 0;
            m_age[i]   = 0;
        end else if (m_mode[i] == M_INIT) begin
            if (is_legal(v)) begin
                m_mode[i] = M_RUN;
                m_prev[i] = v;
                m_held[i] = 1;
            end
        end else if (m_mode[i] == M_RUN) begin
            if (v == m_prev[i]) begin
                m_held[i]++;
            end else begin
                if (!is_legal(v))                        c = 2'b01;
                else if (v != succ(m_prev[i]))            c = 2'b10;
                else if (DWELL_EN && m_held[i] < md[i])   c = 2'b11;
                else                                      c = 2'b00;
                if (c != 2'b00) begin
                    m_mode[i]  = M_FLASH;
                    m_fault[i] = 1'b1;
                    m_fc[i]    = c;
                    m_age[i]   = 0;
                end else begin
                    m_prev[i] = v;
                    m_held[i] = 1;
                end
            end
        end else begin
            m_age[i]++;
        end
    endtask

    function automatic logic [2:0] exp_lamp(input int i);
        if (m_mode[i] == M_INIT) return 3'b100;
        if (m_mode[i] == M_RUN)  return m_prev[i];
        return (((m_age[i] / bh[i]) % 2) == 0) ? 3'b001 : 3'b000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    task automatic step(input logic r, input logic [2:0] v);
        rst      = r;
        light_in = v;
        @(posedge clk);
        cyc++;
        model_edge(0, r, v);
        model_edge(1, r, v);
        #1;
        check_eq("a.lamp",       32'(lamp_a),  32'(exp_lamp(0)));
        check_eq("a.fault",      32'(fault_a), 32'(m_fault[0]));
        check_eq("a.fault_code", 32'(fc_a),    32'(m_fc[0]));
        check_eq("b.lamp",       32'(lamp_b),  32'(exp_lamp(1)));
        check_eq("b.fault",      32'(fault_b), 32'(m_fault[1]));
        check_eq("b.fault_code", 32'(fc_b),    32'(m_fc[1]));
    endtask

    initial begin
        logic [2:0] seq [3];
        logic [2:0] cur;
        int unsigned r;

        seq[0] = 3'b010; seq[1] = 3'b001; seq[2] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_INIT; m_prev[i] = 3'b100; m_held[i] = 0;
            m_age[i] = 0; m_fault[i] = 1'b0; m_fc[i] = 2'b00;
        end
        rst      = 1'b1;
        light_in = 3'b000;

        // reset, then first legal code
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);

        // legal cycling, one code per cycle
        for (int i = 0; i < 30; i++) step(1'b0, seq[(i + 1) % 3]);

        // encoding fault, then legal inputs ignored through several blink periods
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        step(1'b0, 3'b110);
        for (int i = 0; i < 12; i++) step(1'b0, seq[i % 3]);

        // order fault: skip yellow
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        step(1'b0, 3'b100);
        step(1'b0, 3'b010);

        // encoding beats order
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        step(1'b0, 3'b011);
        step(1'b0, 3'b001);

        // dwell: held 2 then 3 before moving on
        step(1'b1, 3'b000);
        step(1'b0, 3'b010); step(1'b0, 3'b010);
        step(1'b0, 3'b001); step(1'b0, 3'b001);
        step(1'b1, 3'b000);
        step(1'b0, 3'b010); step(1'b0, 3'b010); step(1'b0, 3'b010);
        step(1'b0, 3'b001); step(1'b0, 3'b100);

        // reset while flashing lamp is dark, then upstream not yet initialised
        step(1'b1, 3'b000);
        step(1'b0, 3'b010);
        step(1'b0, 3'b110);
        for (int i = 0; i < 5; i++) step(1'b0, 3'b010);
        step(1'b1, 3'b010);
        step(1'b0, 3'b000);
        step(1'b0, 3'b111);
        step(1'b0, 3'b001);

        // randomized traffic with occasional faults and resets
        cur = 3'b010;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                step(1'b1, 3'($urandom_range(0, 7)));
            end else if (r < 9) begin
                step(1'b0, 3'($urandom_range(0, 7)));
            end else if (r < 13) begin
                cur = succ(succ(cur));
                step(1'b0, cur);
            end else if (r < 55) begin
                step(1'b0, cur);
            end else begin
                cur = succ(cur);
                step(1'b0, cur);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
